// File: rtl/robo_seguidor.sv
// robo_seguidor: wall-following controller for the lab robot.
// Debounces the head/left/right contact sensors, follows the left or right
// wall (chosen by `lado`), backs off after a rotation timeout and counts
// forward-driving cycles in a saturating counter.
// `estado` is a debug view of the FSM state register.
module robo_seguidor #(
  parameter int DEB     = 2,
  parameter int ROT_MAX = 8,
  parameter int RECUO   = 3,
  parameter int CW      = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          head,
  input  logic          left,
  input  logic          right,
  input  logic          lado,
  output logic          avancar,
  output logic          girar,
  output logic          sentido,
  output logic          recuar,
  output logic          travado,
  output logic [CW-1:0] passos,
  output logic [2:0]    estado
);

  typedef enum logic [2:0] {
    PROCURANDO   = 3'd0,
    ROTACIONANDO = 3'd1,
    ACOMPANHANDO = 3'd2,
    CONTORNANDO  = 3'd3,
    RECUANDO     = 3'd4
  } state_t;

  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam int RW = $clog2(ROT_MAX);
  localparam int QW = (RECUO > 1) ? $clog2(RECUO) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
  localparam logic [RW-1:0] ROT_LAST = RW'(ROT_MAX - 1);
  localparam logic [QW-1:0] REC_LAST = QW'(RECUO - 1);
  localparam logic [CW-1:0] PASSOS_MAX = {CW{1'b1}};

  // Sensor order: bit 0 head, bit 1 left, bit 2 right.
  logic [2:0] raw;
  logic [2:0] filt;
  assign raw = {right, left, head};

  genvar g;
  for (g = 0; g < 3; g++) begin : g_filt
    logic          f;
    logic [DW-1:0] c;
    // Debounce: the filtered bit follows raw only after DEB consecutive
    // disagreeing cycles; any agreement restarts the count.
    always_ff @(posedge clock) begin
      if (reset) begin
        f <= 1'b0;
        c <= '0;
      end else if (raw[g] == f) begin
        c <= '0;
      end else if (c == DEB_LAST) begin
        f <= raw[g];
        c <= '0;
      end else begin
        c <= c + 1'b1;
      end
    end
    assign filt[g] = f;
  end

  state_t        state_q, state_d;
  logic          lado_r;
  logic [RW-1:0] rot_cnt;
  logic [QW-1:0] rec_cnt;
  logic          h, p;

  assign h = filt[0];
  assign p = lado_r ? filt[2] : filt[1];

  // Next-state logic; first matching condition wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PROCURANDO: begin
        if (h)      state_d = ROTACIONANDO;
        else if (p) state_d = ACOMPANHANDO;
      end
      ROTACIONANDO: begin
        if (!h && p)                state_d = ACOMPANHANDO;
        else if (rot_cnt == ROT_LAST) state_d = RECUANDO;
      end
      ACOMPANHANDO: begin
        if (h)       state_d = ROTACIONANDO;
        else if (!p) state_d = CONTORNANDO;
      end
      CONTORNANDO: state_d = PROCURANDO;
      RECUANDO: begin
        if (rec_cnt == REC_LAST) state_d = ROTACIONANDO;
      end
      default: state_d = PROCURANDO;
    endcase
  end

  // State register, dwell counters (cleared on every entry), side latch,
  // timeout flag and forward-step counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PROCURANDO;
      lado_r  <= 1'b0;
      rot_cnt <= '0;
      rec_cnt <= '0;
      travado <= 1'b0;
      passos  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == PROCURANDO) lado_r <= lado;
      if (state_q == ROTACIONANDO && state_d == ROTACIONANDO) rot_cnt <= rot_cnt + 1'b1;
      else rot_cnt <= '0;
      if (state_q == RECUANDO && state_d == RECUANDO) rec_cnt <= rec_cnt + 1'b1;
      else rec_cnt <= '0;
      travado <= (state_q == ROTACIONANDO) && (state_d == RECUANDO);
      if (avancar && passos != PASSOS_MAX) passos <= passos + 1'b1;
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    avancar = 1'b0;
    girar   = 1'b0;
    sentido = 1'b0;
    recuar  = 1'b0;
    case (state_q)
      PROCURANDO, ACOMPANHANDO: avancar = 1'b1;
      ROTACIONANDO: begin
        girar   = 1'b1;
        sentido = lado_r;
      end
      CONTORNANDO: begin
        girar   = 1'b1;
        sentido = ~lado_r;
      end
      RECUANDO: recuar = 1'b1;
      default: ;
    endcase
  end

  assign estado = state_q;

endmodule
